key_expand_seq: RTL

KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

---
 rtl/key_expand_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/key_expand_seq.sv
// AES-128 key schedule: streams round keys 0..10 one per accepted handshake; key 0 valid 1 cycle after start.
// rk_out/rk_idx hold while rk_valid && !rk_ready; done pulses once after key 10 transfers.
module key_expand_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {IDLE, EMIT} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     idx_q, idx_d;
  logic           vld_q, vld_d;
  logic           done_q, done_d;

  logic [7:0]     rcon;
  logic [31:0]    w0, w1, w2, w3, t;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   rk_next;

  always_comb begin
    rcon = 8'h00;
    case (idx_q)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Next round key is derived combinationally from the registered key so the
  // schedule advances one key per handshake with a single register stage.
  assign {w0, w1, w2, w3} = rk_q;
  assign t       = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (start) begin
          state_d = EMIT;
          rk_d    = key_in;
          idx_d   = 4'd0;
          vld_d   = 1'b1;
        end
      end
      EMIT: begin
        if (vld_q && rk_ready) begin
          if (idx_q == 4'd10) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            rk_d  = rk_next;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign rk_out   = rk_q;
  assign rk_idx   = idx_q;
  assign rk_valid = vld_q;
  assign done     = done_q;
  assign busy     = (state_q == EMIT);

endmodule
